// File: rtl/sub_dispatch_if.sv
// Handshake bundle between the operand dispatcher, its two operand FIFOs,
// the arithmetic unit and the result FIFO.
interface sub_dispatch_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] a_dout;
    logic                  a_empty;
    logic                  a_rd_en;
    logic [DATA_WIDTH-1:0] b_dout;
    logic                  b_empty;
    logic                  b_rd_en;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic                  op_valid;
    logic [DATA_WIDTH-1:0] res_in;
    logic                  res_done;
    logic                  res_ack;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;
    logic                  out_wr_en;

    modport master (
        input  a_dout, a_empty, b_dout, b_empty, res_in, res_done, out_full,
        output a_rd_en, b_rd_en, op1, op2, op_valid, res_ack, out_din, out_wr_en
    );

    modport slave (
        output a_dout, a_empty, b_dout, b_empty, res_in, res_done, out_full,
        input  a_rd_en, b_rd_en, op1, op2, op_valid, res_ack, out_din, out_wr_en
    );
endinterface

// File: rtl/sub_dispatch.sv
// Operand dispatcher / result collector: pops an operand pair, issues it to a
// single-cycle unit, writes the result out. Define SUB_DISPATCH_TIMEOUT_EN for the WAIT watchdog.
module sub_dispatch #(
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    sub_dispatch_if.master       bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 timeout_err
);

`ifdef SUB_DISPATCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic                  op_valid_q, op_valid_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
    logic                  pop;
    logic                  write;

`ifdef SUB_DISPATCH_TIMEOUT_EN
    logic [TMO_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        op_count_d = op_count_q;
        pop        = 1'b0;
        write      = 1'b0;
`ifdef SUB_DISPATCH_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                // Only a complete pair is ever popped.
                if (!bus.a_empty && !bus.b_empty) begin
                    pop     = 1'b1;
                    op1_d   = bus.a_dout;
                    op2_d   = bus.b_dout;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SUB_DISPATCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            WAIT: begin
                // A full output FIFO leaves the result parked in the unit.
                if (bus.res_done && !bus.out_full) begin
                    write      = 1'b1;
                    op_count_d = op_count_q + CNT_WIDTH'(1);
                    state_d    = IDLE;
                end
`ifdef SUB_DISPATCH_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_cnt_q + TMO_W'(1);
                    if (wait_cnt_d == TMO_W'(TIMEOUT_CYCLES)) begin
                        state_d       = HALT;
                        timeout_err_d = 1'b1;
                    end
                end
`endif
            end
`ifdef SUB_DISPATCH_TIMEOUT_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        op_valid_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op1_q      <= '0;
            op2_q      <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            op_count_q <= '0;
`ifdef SUB_DISPATCH_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            op_count_q <= op_count_d;
`ifdef SUB_DISPATCH_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Pops are held off while reset is asserted so a reset never consumes FIFO words.
    assign bus.a_rd_en   = pop & ~reset;
    assign bus.b_rd_en   = pop & ~reset;
    assign bus.op1       = op1_q;
    assign bus.op2       = op2_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.res_ack   = write;
    assign bus.out_wr_en = write;
    assign bus.out_din   = bus.res_in;
    assign busy          = busy_q;
    assign op_count      = op_count_q;

`ifdef SUB_DISPATCH_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_sub_dispatch.sv
// Scoreboard bench for sub_dispatch: FIFO/subtractor environment, in-order
// result queue and a per-cycle handshake model checked on the falling edge.
module tb_sub_dispatch;
    localparam int DW  = 32;
    localparam int CW  = 2;
    localparam int TMO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic [CW-1:0] op_count;
    logic          timeout_err;

    always #5 clock = ~clock;

    sub_dispatch_if #(.DATA_WIDTH(DW)) bus ();

    sub_dispatch #(
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .op_count   (op_count),
        .timeout_err(timeout_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] qa[$], qb[$];       // FIFO contents seen by the DUT
    logic [DW-1:0] pa[$], pb[$];       // pushed words not yet paired
    logic [DW-1:0] exp_q[$];           // expected results, in order

    logic          s_pop_a = 1'b0, s_pop_b = 1'b0, s_opv = 1'b0, s_ack = 1'b0;
    logic [DW-1:0] s_op1 = '0, s_op2 = '0;
    bit            unit_dead = 1'b0;

    // reference model state
    bit            in_flight = 1'b0, issue_next = 1'b0, halted = 1'b0;
    int            wait_run = 0;
    logic [CW-1:0] m_cnt = '0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    bit            exp_pop, exp_opv, in_wait, exp_wr;
    logic [DW-1:0] exp_res;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            s_pop_a = bus.a_rd_en;
            s_pop_b = bus.b_rd_en;
            s_opv   = bus.op_valid;
            s_ack   = bus.res_ack;
            s_op1   = bus.op1;
            s_op2   = bus.op2;
            if (reset) begin
                check("reset_strobes", {bus.a_rd_en, bus.b_rd_en, bus.op_valid, bus.res_ack,
                                        bus.out_wr_en, busy, timeout_err}, 64'd0);
                check("reset_op_count", op_count, 64'd0);
                check("reset_op1", bus.op1, 64'd0);
                check("reset_op2", bus.op2, 64'd0);
                if (in_flight && exp_q.size() > 0) void'(exp_q.pop_front());
                in_flight  = 1'b0;
                issue_next = 1'b0;
                halted     = 1'b0;
                wait_run   = 0;
                m_cnt      = '0;
            end else begin
                exp_pop = !in_flight && !halted && !bus.a_empty && !bus.b_empty;
                exp_opv = issue_next;
                in_wait = in_flight && !issue_next && !halted;
                exp_wr  = in_wait && bus.res_done && !bus.out_full;
                check("a_rd_en", bus.a_rd_en, exp_pop);
                check("b_rd_en", bus.b_rd_en, exp_pop);
                check("op_valid", bus.op_valid, exp_opv);
                check("out_wr_en", bus.out_wr_en, exp_wr);
                check("res_ack", bus.res_ack, exp_wr);
                check("busy", busy, in_flight || halted);
                check("timeout_err", timeout_err, halted);
                check("op_count", op_count, m_cnt);
                if (in_flight && !halted) begin
                    check("op1_stable", bus.op1, m_a);
                    check("op2_stable", bus.op2, m_b);
                end
                if (exp_wr) begin
                    if (exp_q.size() == 0) begin
                        check("result_queue_nonempty", 64'd0, 64'd1);
                    end else begin
                        exp_res = exp_q.pop_front();
                        check("result", bus.out_din, exp_res);
                    end
                end
                issue_next = 1'b0;
                if (exp_pop) begin
                    in_flight  = 1'b1;
                    issue_next = 1'b1;
                    m_a        = bus.a_dout;
                    m_b        = bus.b_dout;
                    wait_run   = 0;
                end
                if (in_wait && !exp_wr) begin
                    wait_run++;
`ifdef SUB_DISPATCH_TIMEOUT_EN
                    if (wait_run == TMO) halted = 1'b1;
`endif
                end
                if (exp_wr) begin
                    in_flight = 1'b0;
                    m_cnt     = m_cnt + CW'(1);
                end
            end
        end
    end

    task automatic drive();
        bus.a_empty = (qa.size() == 0);
        bus.b_empty = (qb.size() == 0);
        bus.a_dout  = (qa.size() == 0) ? DW'($urandom) : qa[0];
        bus.b_dout  = (qb.size() == 0) ? DW'($urandom) : qb[0];
    endtask

    // One clock: apply what the DUT did at this edge, then drive new inputs.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (s_pop_a && qa.size() > 0) void'(qa.pop_front());
        if (s_pop_b && qb.size() > 0) void'(qb.pop_front());
        if (s_ack) bus.res_done = 1'b0;
        if (s_opv && !unit_dead) begin
            bus.res_done = 1'b1;
            bus.res_in   = s_op1 - s_op2;
        end
        if (reset) bus.res_done = 1'b0;
        drive();
    endtask

    task automatic pair_up();
        logic [DW-1:0] x, y, d;
        while (pa.size() > 0 && pb.size() > 0) begin
            x = pa.pop_front();
            y = pb.pop_front();
            d = x - y;
            exp_q.push_back(d);
        end
    endtask

    task automatic push_a(input logic [DW-1:0] v);
        qa.push_back(v);
        pa.push_back(v);
        pair_up();
        drive();
    endtask

    task automatic push_b(input logic [DW-1:0] v);
        qb.push_back(v);
        pb.push_back(v);
        pair_up();
        drive();
    endtask

    task automatic wait_pop();
        bit got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (s_pop_a) begin
                got = 1'b1;
                break;
            end
        end
        check("pop_seen", got, 64'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !in_flight) break;
            cycle();
        end
        repeat (2) cycle();
        check("drain_empty", exp_q.size(), 64'd0);
    endtask

    task automatic do_reset();
        cycle();
        reset        = 1'b1;
        bus.res_done = 1'b0;
        drive();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int full_run;
        bus.a_empty  = 1'b1;
        bus.b_empty  = 1'b1;
        bus.a_dout   = '0;
        bus.b_dout   = '0;
        bus.res_in   = '0;
        bus.res_done = 1'b0;
        bus.out_full = 1'b0;
        repeat (3) cycle();
        reset = 1'b0;

        // single operation
        push_a(32'h0000_000A);
        push_b(32'h0000_0003);
        drain(20);

        // unbalanced FIFOs: A holds two words, B empty
        push_a(32'h11);
        push_a(32'h22);
        repeat (10) cycle();
        push_b(32'h1);
        repeat (6) cycle();
        push_b(32'h2);
        drain(20);

        // output back-pressure during the first WAIT
        push_a(5); push_b(1);
        push_a(0); push_b(1);
        push_a(7); push_b(2);
        push_a(9); push_b(9);
        wait_pop();
        cycle();
        bus.out_full = 1'b1;
        repeat (5) cycle();
        bus.out_full = 1'b0;
        drain(60);

        // counter wrap with a 2-bit count
        for (int i = 0; i < 5; i++) begin
            push_a(rand_word());
            push_b(rand_word());
            drain(20);
        end

        // reset while waiting on a stalled write
        push_a(100);
        push_b(40);
        wait_pop();
        cycle();
        bus.out_full = 1'b1;
        cycle();
        cycle();
        do_reset();
        bus.out_full = 1'b0;
        push_a(50);
        push_b(8);
        drain(20);

        // randomized traffic with bounded back-pressure
        full_run = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (qa.size() < 4 && $urandom_range(0, 1) == 1) push_a(rand_word());
            if (qb.size() < 4 && $urandom_range(0, 1) == 1) push_b(rand_word());
            if (full_run >= 3) bus.out_full = 1'b0;
            else bus.out_full = ($urandom_range(0, 3) == 0);
            full_run = bus.out_full ? full_run + 1 : 0;
        end
        bus.out_full = 1'b0;
        drain(100);

        // unit never completes: watchdog (or indefinite wait without it)
        unit_dead = 1'b1;
        push_a(32'h30);
        push_b(32'h10);
        repeat (20) cycle();
        push_a(32'h44);
        push_b(32'h04);
        repeat (5) cycle();
        do_reset();
        unit_dead = 1'b0;
        drain(30);

        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
